// File: rtl/race_pkg.sv
// Shared widths and helpers for the race progress tracker.
// Checkpoint tables arrive as packed parameter vectors and are sliced here.
package race_pkg;

  localparam int RANKW = 4;
  localparam int LAPW  = 4;
  localparam int MAXW  = 16;
  localparam int MAXCP = 16;
  localparam int VECW  = MAXW * MAXCP;

  function automatic int cpw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAXW-1:0] cp_slice(
    input logic [VECW-1:0] v,
    input int              w,
    input int              i
  );
    logic [VECW-1:0] s;
    s = v >> (i * w);
    return s[MAXW-1:0];
  endfunction

  function automatic logic [MAXW-1:0] cp_x(
    input logic [VECW-1:0] v,
    input int              w,
    input int              i
  );
    return cp_slice(v, w, i);
  endfunction

  function automatic logic [MAXW-1:0] cp_y(
    input logic [VECW-1:0] v,
    input int              w,
    input int              i
  );
    return cp_slice(v, w, i);
  endfunction

  function automatic logic [MAXW-1:0] abs_diff(
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/race_progress_tracker_checkpoint_hit.sv
// Square hit-box test of a point against a checkpoint centre.
// Pure combinational; the debug overlay can reuse it as-is.
module checkpoint_hit
  import race_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int CP_HALF = 8
) (
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  output logic               hit_o
);

  logic [MAXW-1:0] dx;
  logic [MAXW-1:0] dy;

  assign dx = abs_diff(MAXW'(px_i), MAXW'(cx_i));
  assign dy = abs_diff(MAXW'(py_i), MAXW'(cy_i));

  assign hit_o = (dx <= MAXW'(CP_HALF)) &&
                 (dy <= MAXW'(CP_HALF));

endmodule

// File: rtl/race_progress_tracker.sv
// Round-robin lap/checkpoint/finish-order tracker for N racers.
// One player is box-tested per clock, then committed a clock later.
module race_progress_tracker
  import race_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int N_CP      = 4,
  parameter int N_LAPS    = 3,
  parameter int COORD_W   = 10,
  parameter logic [N_CP*COORD_W-1:0] CP_X = '0,
  parameter logic [N_CP*COORD_W-1:0] CP_Y = '0,
  parameter int CP_HALF   = 8,
  parameter int TIME_W    = 16,
  parameter int END_ON_FIRST = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              race_active,
  input  logic                              race_clear,
  input  logic                              time_tick,
  input  logic [N_PLAYERS*COORD_W-1:0]      pos_x,
  input  logic [N_PLAYERS*COORD_W-1:0]      pos_y,
  output logic [N_PLAYERS*$clog2(N_CP)-1:0] next_cp,
  output logic [N_PLAYERS*LAPW-1:0]         lap,
  output logic [N_PLAYERS-1:0]              cp_pulse,
  output logic [N_PLAYERS-1:0]              finished,
  output logic [N_PLAYERS*RANKW-1:0]        rank,
  output logic [N_PLAYERS*TIME_W-1:0]       finish_time,
  output logic [TIME_W-1:0]                 race_time,
  output logic                              game_end
);

  localparam int CPW = $clog2(N_CP);
  localparam int PW  = cpw(N_PLAYERS);
  localparam logic [VECW-1:0] CPX_EXT = VECW'(CP_X);
  localparam logic [VECW-1:0] CPY_EXT = VECW'(CP_Y);
  localparam logic [N_PLAYERS*CPW-1:0] CP_RST =
    {N_PLAYERS{CPW'(1)}};

  logic [COORD_W-1:0] cx_tab [N_CP];
  logic [COORD_W-1:0] cy_tab [N_CP];

  for (genvar i = 0; i < N_CP; i++) begin : g_tab
    assign cx_tab[i] = COORD_W'(cp_x(CPX_EXT, COORD_W, i));
    assign cy_tab[i] = COORD_W'(cp_y(CPY_EXT, COORD_W, i));
  end

  logic [PW-1:0]               ptr_q, ptr_d;
  logic [PW-1:0]               s1_p_q, s1_p_d;
  logic [CPW-1:0]              s1_cp_q, s1_cp_d;
  logic                        s1_hit_q, s1_hit_d;
  logic [N_PLAYERS*CPW-1:0]    next_cp_q, next_cp_d;
  logic [N_PLAYERS*LAPW-1:0]   lap_q, lap_d;
  logic [N_PLAYERS-1:0]        pulse_q, pulse_d;
  logic [N_PLAYERS-1:0]        fin_q, fin_d;
  logic [N_PLAYERS*RANKW-1:0]  rank_q, rank_d;
  logic [N_PLAYERS*TIME_W-1:0] ftime_q, ftime_d;
  logic [TIME_W-1:0]           time_q, time_d;
  logic                        gend_q, gend_d;
  logic [RANKW-1:0]            nrank_q, nrank_d;

  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;
  logic [CPW-1:0]     cur_cp;
  logic               hit;

  assign px     = pos_x[ptr_q*COORD_W +: COORD_W];
  assign py     = pos_y[ptr_q*COORD_W +: COORD_W];
  assign cur_cp = next_cp_q[ptr_q*CPW +: CPW];

  checkpoint_hit #(
    .COORD_W (COORD_W),
    .CP_HALF (CP_HALF)
  ) u_hit (
    .px_i  (px),
    .py_i  (py),
    .cx_i  (cx_tab[cur_cp]),
    .cy_i  (cy_tab[cur_cp]),
    .hit_o (hit)
  );

  logic            upd;
  logic            is_lap;
  logic [LAPW-1:0] new_lap;
  logic [CPW-1:0]  adv_cp;

  // Stale hits are dropped if the player's target moved since sampling.
  assign upd = s1_hit_q && race_active && !gend_q &&
               !fin_q[s1_p_q] &&
               (s1_cp_q == next_cp_q[s1_p_q*CPW +: CPW]);
  assign is_lap  = (s1_cp_q == '0);
  assign new_lap = lap_q[s1_p_q*LAPW +: LAPW] + LAPW'(1);
  assign adv_cp  = (s1_cp_q == CPW'(N_CP - 1)) ?
                   '0 : s1_cp_q + CPW'(1);

  always_comb begin
    ptr_d    = (ptr_q == PW'(N_PLAYERS - 1)) ?
               '0 : ptr_q + PW'(1);
    s1_p_d   = ptr_q;
    s1_cp_d  = cur_cp;
    s1_hit_d = hit;
    next_cp_d = next_cp_q;
    lap_d    = lap_q;
    pulse_d  = '0;
    fin_d    = fin_q;
    rank_d   = rank_q;
    ftime_d  = ftime_q;
    nrank_d  = nrank_q;
    time_d   = time_q;
    gend_d   = gend_q |
               ((END_ON_FIRST != 0) ? |fin_q : &fin_q);

    if (time_tick && race_active && !gend_q &&
        time_q != '1)
      time_d = time_q + TIME_W'(1);

    if (upd) begin
      pulse_d[s1_p_q] = 1'b1;
      if (is_lap) begin
        lap_d[s1_p_q*LAPW +: LAPW] = new_lap;
        next_cp_d[s1_p_q*CPW +: CPW] = CPW'(1);
        if (new_lap == LAPW'(N_LAPS)) begin
          fin_d[s1_p_q] = 1'b1;
          rank_d[s1_p_q*RANKW +: RANKW] = nrank_q;
          ftime_d[s1_p_q*TIME_W +: TIME_W] = time_q;
          nrank_d = nrank_q + RANKW'(1);
        end
      end else begin
        next_cp_d[s1_p_q*CPW +: CPW] = adv_cp;
      end
    end

    if (race_clear) begin
      ptr_d     = '0;
      s1_p_d    = '0;
      s1_cp_d   = '0;
      s1_hit_d  = 1'b0;
      next_cp_d = CP_RST;
      lap_d     = '0;
      pulse_d   = '0;
      fin_d     = '0;
      rank_d    = '0;
      ftime_d   = '0;
      nrank_d   = RANKW'(1);
      time_d    = '0;
      gend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      s1_p_q    <= '0;
      s1_cp_q   <= '0;
      s1_hit_q  <= 1'b0;
      next_cp_q <= CP_RST;
      lap_q     <= '0;
      pulse_q   <= '0;
      fin_q     <= '0;
      rank_q    <= '0;
      ftime_q   <= '0;
      nrank_q   <= RANKW'(1);
      time_q    <= '0;
      gend_q    <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      s1_p_q    <= s1_p_d;
      s1_cp_q   <= s1_cp_d;
      s1_hit_q  <= s1_hit_d;
      next_cp_q <= next_cp_d;
      lap_q     <= lap_d;
      pulse_q   <= pulse_d;
      fin_q     <= fin_d;
      rank_q    <= rank_d;
      ftime_q   <= ftime_d;
      nrank_q   <= nrank_d;
      time_q    <= time_d;
      gend_q    <= gend_d;
    end
  end

  assign next_cp     = next_cp_q;
  assign lap         = lap_q;
  assign cp_pulse    = pulse_q;
  assign finished    = fin_q;
  assign rank        = rank_q;
  assign finish_time = ftime_q;
  assign race_time   = time_q;
  assign game_end    = gend_q;

endmodule

// File: tb/tb_race_progress_tracker.sv
// Directed checks of the race tracker: ordering, pause, tie,
// timer saturation, race_clear and async reset.
module tb_race_progress_tracker;

  localparam int N  = 2;
  localparam int CW = 10;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic race_active;
  logic race_clear;
  logic time_tick;
  logic [N*CW-1:0] pos_x;
  logic [N*CW-1:0] pos_y;
  logic [N*2-1:0]  next_cp;
  logic [N*4-1:0]  lap;
  logic [N-1:0]    cp_pulse;
  logic [N-1:0]    finished;
  logic [N*4-1:0]  rank;
  logic [N*TW-1:0] finish_time;
  logic [TW-1:0]   race_time;
  logic            game_end;

  int n_cmp = 0;
  int n_bad = 0;
  int ph;
  int c0;
  int c1;

  always #5 clk = ~clk;

  race_progress_tracker #(
    .N_PLAYERS    (N),
    .N_CP         (4),
    .N_LAPS       (1),
    .COORD_W      (CW),
    .CP_X         ({10'd100, 10'd200, 10'd100, 10'd20}),
    .CP_Y         ({10'd200, 10'd125, 10'd40, 10'd125}),
    .CP_HALF      (8),
    .TIME_W       (TW),
    .END_ON_FIRST (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .race_active (race_active),
    .race_clear  (race_clear),
    .time_tick   (time_tick),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .next_cp     (next_cp),
    .lap         (lap),
    .cp_pulse    (cp_pulse),
    .finished    (finished),
    .rank        (rank),
    .finish_time (finish_time),
    .race_time   (race_time),
    .game_end    (game_end)
  );

  // Bench-side scan phase: which player the next edge samples.
  always @(posedge clk or posedge rst) begin
    if (rst)             ph <= 0;
    else if (race_clear) ph <= 0;
    else                 ph <= (ph == N - 1) ? 0 : ph + 1;
  end

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic place(input int p, input int x, input int y);
    pos_x[p*CW +: CW] = CW'(x);
    pos_y[p*CW +: CW] = CW'(y);
  endtask

  task automatic watch(input int p, input int cyc,
                       output int cnt);
    cnt = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (cp_pulse[p]) cnt++;
    end
  endtask

  task automatic move(input int p, input int x, input int y,
                      input int exp, input string tag);
    int c;
    place(p, x, y);
    watch(p, 4, c);
    chk(tag, c, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      time_tick = 1'b1;
      @(negedge clk);
    end
    time_tick = 1'b0;
  endtask

  initial begin
    race_active = 1'b0;
    race_clear  = 1'b0;
    time_tick   = 1'b0;
    pos_x = '0;
    pos_y = '0;
    place(0, 500, 500);
    place(1, 500, 500);
    #1 rst = 1'b1;
    #11;
    chk("rst_next_cp", int'(next_cp), 5);
    chk("rst_lap", int'(lap), 0);
    chk("rst_rank", int'(rank), 0);
    chk("rst_fin", int'(finished), 0);
    chk("rst_time", int'(race_time), 0);
    chk("rst_gend", int'(game_end), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    race_active = 1'b1;
    ticks(3);
    chk("time_3", int'(race_time), 3);

    move(0, 200, 125, 0, "skip_pulse");
    chk("skip_cp", int'(next_cp[1:0]), 1);

    race_active = 1'b0;
    place(0, 100, 40);
    c0 = 0;
    repeat (5) begin
      time_tick = 1'b1;
      @(negedge clk);
      if (cp_pulse[0]) c0++;
    end
    time_tick = 1'b0;
    chk("pause_pulse", c0, 0);
    chk("pause_time", int'(race_time), 3);
    chk("pause_cp", int'(next_cp[1:0]), 1);

    race_active = 1'b1;
    watch(0, 3, c0);
    chk("resume_pulse", c0, 1);
    chk("resume_cp", int'(next_cp[1:0]), 2);

    move(0, 200, 125, 1, "p0_cp2");
    chk("p0_cp_3", int'(next_cp[1:0]), 3);
    move(0, 100, 200, 1, "p0_cp3");
    chk("p0_cp_0", int'(next_cp[1:0]), 0);
    chk("p0_lap0", int'(lap), 0);

    ticks(20);
    chk("time_sat", int'(race_time), 15);

    move(1, 100, 40, 1, "p1_cp1");
    move(1, 200, 125, 1, "p1_cp2");
    move(1, 100, 200, 1, "p1_cp3");
    chk("both_cp0", int'(next_cp), 0);

    if (ph != 0) @(negedge clk);
    place(0, 20, 125);
    place(1, 20, 125);
    c0 = 0;
    c1 = 0;
    repeat (5) begin
      @(negedge clk);
      if (cp_pulse[0]) c0++;
      if (cp_pulse[1]) c1++;
    end
    chk("tie_pulse0", c0, 1);
    chk("tie_pulse1", c1, 1);
    chk("tie_rank0", int'(rank[3:0]), 1);
    chk("tie_rank1", int'(rank[7:4]), 2);
    chk("tie_fin", int'(finished), 3);
    chk("tie_lap", int'(lap), 8'h11);
    chk("tie_ftime", int'(finish_time), 8'hFF);
    chk("tie_cp", int'(next_cp), 5);
    chk("tie_gend", int'(game_end), 1);

    race_clear = 1'b1;
    @(negedge clk);
    race_clear = 1'b0;
    chk("clr_next_cp", int'(next_cp), 5);
    chk("clr_lap", int'(lap), 0);
    chk("clr_fin", int'(finished), 0);
    chk("clr_rank", int'(rank), 0);
    chk("clr_ftime", int'(finish_time), 0);
    chk("clr_time", int'(race_time), 0);
    chk("clr_gend", int'(game_end), 0);

    move(0, 100, 40, 1, "post_clr_cp1");
    chk("post_clr_cp", int'(next_cp), 6);
    ticks(2);
    chk("post_clr_time", int'(race_time), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_next_cp", int'(next_cp), 5);
    chk("arst_time", int'(race_time), 0);
    chk("arst_pulse", int'(cp_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_hold_cp", int'(next_cp), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/race_progress_tracker.md
Name: race_progress_tracker

Overview:
- Parametrised lap, checkpoint and finish-order tracker for N racers, driven by PhysicsEngine world coordinates.
- Replaces the fixed 2-player flag/finish logic and supplies `is_game_end` to StateEncoder.
- Supplies ranks and lap counters to the HUD.
- Players are evaluated round-robin, one per clock. Finish order is therefore unique even when players cross on the same cycle.

Parameters:
- N_PLAYERS, 2, number of racers (1..8)
- N_CP, 4, checkpoints per lap; index 0 is the start/finish line (2..16)
- N_LAPS, 3, laps to finish (1..15)
- COORD_W, 10, world-coordinate width
- CP_X, {4{10'd0}}, packed N_CP×COORD_W checkpoint centre X; entry i at bits [i*COORD_W +: COORD_W]
- CP_Y, {4{10'd0}}, packed checkpoint centre Y, same packing
- CP_HALF, 8, half-size of the square checkpoint hit box, in world pixels
- TIME_W, 16, race timer width
- END_ON_FIRST, 0, 1 = `game_end` when first racer finishes; 0 = when all finish

Ports:
- clk, in, 1, system clock
- rst, in, 1, reset; asynchronous, active-high
- race_active, in, 1, high while state==RACING; low freezes all progress and the timer
- race_clear, in, 1, synchronous pulse; returns everything to reset values
- time_tick, in, 1, single-cycle timer enable (e.g. 100 Hz)
- pos_x, in, N_PLAYERS×COORD_W, packed player world X; player p at [p*COORD_W +: COORD_W]
- pos_y, in, N_PLAYERS×COORD_W, packed player world Y
- next_cp, out, N_PLAYERS×CPW, checkpoint each player must hit next (CPW = $clog2(N_CP))
- lap, out, N_PLAYERS×4, completed laps per player
- cp_pulse, out, N_PLAYERS, one-cycle strobe when a player's checkpoint is accepted
- finished, out, N_PLAYERS, sticky finish flag
- rank, out, N_PLAYERS×4, finish position 1..N; 0 while not finished
- finish_time, out, N_PLAYERS×TIME_W, `race_time` latched at finish
- race_time, out, TIME_W, elapsed race ticks
- game_end, out, 1, level, held until rst/race_clear

Behaviour:
- Reset (rst async, or race_clear sync): all outputs 0, except every `next_cp` = 1. Internal `ptr` = 0, `next_rank` = 1.
- Timer:
  - `race_time` increments on `time_tick` when race_active && !game_end.
  - Saturates at all-ones; never wraps.
- Scan pointer:
  - `ptr` cycles 0..N_PLAYERS-1 every clock, irrespective of `race_active`, wrapping to 0.
- Stage 1 (registered), on the cycle `ptr`==p:
  - Capture p, `pos_x[p]`, `pos_y[p]`, and `hit`.
  - `hit` = |pos_x - CP_X[next_cp[p]]| <= CP_HALF && |pos_y - CP_Y[next_cp[p]]| <= CP_HALF.
  - Compare unsigned, using mux-abs only; no multipliers.
- Stage 2 (registered, one cycle after stage 1), update p only if stage-1 `hit` && race_active && !finished[p]:
  - `cp_pulse[p]` = 1 for exactly this cycle.
  - If `next_cp[p]` != 0: `next_cp[p]` = (`next_cp[p]` + 1) mod N_CP.
  - If `next_cp[p]` == 0:
    - `lap[p]` += 1, and `next_cp[p]` = 1.
    - If the new lap == N_LAPS: `finished[p]` = 1, `rank[p]` = `next_rank`, `finish_time[p]` = `race_time`, `next_rank` += 1.
- Latency: position sample to output update = 2 clocks. Worst case from a position change = N_PLAYERS + 1 clocks.
- Ordering: checkpoints must be hit in order. Hitting a non-next checkpoint is ignored. Re-entering the same box after acceptance does not double count, because `next_cp` has already advanced.
- `game_end`:
  - END_ON_FIRST=1: set the cycle after the first `finished` bit sets.
  - END_ON_FIRST=0: set once all `finished` bits are 1.
  - Once set, no further progress is accepted; `rank` of unfinished players stays 0.
- Simultaneous arrival: the player scanned first ranks higher; ranks are always distinct.
- `race_active` falling mid-pipeline: the pending stage-2 update is discarded (no pulse).
- rst mid-race: immediate clear; no partial update survives.

Decomposition:
- Package `race_pkg`:
  - CPW, RANKW (= 4), LAPW (= 4) width localparams.
  - Functions `cp_x(i)`/`cp_y(i)` for slicing the packed parameter vectors.
  - `abs_diff` function.
- Sub-module `checkpoint_hit`:
  - Combinational box test (px, py, cx, cy, CP_HALF → hit).
  - Reusable by the debug overlay.

Test Plan:
- N=2, N_CP=4, N_LAPS=1, CP0=(20,125), CP1=(100,40), CP2=(200,125), CP3=(100,200):
  - Drive P0 to CP1, CP2, CP3, CP0 with race_active=1.
  - Expect `cp_pulse[0]` ×4, `next_cp[0]` 1→2→3→0→1, `lap[0]`=1, `finished[0]`=1, `rank[0]`=1.
- Skip check: P0 goes straight to CP2 → no pulse, `next_cp[0]` stays 1. Then CP1 → accepted.
- Tie: both players reach CP0 on the same cycle for the final lap → `rank[0]`=1, `rank[1]`=2. With END_ON_FIRST=0, `game_end`=1.
- Pause: race_active=0 while P0 sits in the CP1 box, time_tick pulsing → no pulse, `race_time` frozen. Raise race_active → accepted within N+1 clocks.
- Timer: TIME_W=4, 20 ticks → `race_time` saturates at 15. `finish_time` latches 15.
- Async rst asserted mid-lap, between clock edges → outputs zero immediately, `next_cp`=1 for all players. race_clear pulse gives the identical result one clock later.
